trng_coord_sampler: RTL
=======================

// Module: trng_coord_sampler
// PURPOSE
//  Consumer end of the TRNG interface. Drives the TRNG resolution input and captures its scaled random
//  output, alternating between GRID_W and GRID_H bounds to form (x,y) grain-drop coordinates for the
//  sandpile core. Buffers coordinates in a small FIFO behind a valid/ready port and runs a
//  repetition-count health test on every raw capture.
// PARAMETERS
//  GRID_W      20  x bound, drives resolution during x phase; 2..511
//  GRID_H      24  y bound, drives resolution during y phase; 2..511
//  WARMUP      8   cycles after reset before first capture (loads TRNG product register, which has no reset)
//  RCT_CUTOFF  6   consecutive identical raw captures that trip health_fail; 2..15
//  FIFO_DEPTH  4   coordinate FIFO entries, power of 2
// PORTS
//  clk          in   1                clock
//  rst_n        in   1                synchronous, active-low reset
//  en           in   1                sampling enable; 0 = FSM holds in HOLD
//  random_in    in   10               TRNG random_out
//  resolution_o out  9                TRNG resolution, registered
//  out_valid    out  1                FIFO not empty
//  out_ready    in   1                consumer accepts head entry
//  out_x        out  $clog2(GRID_W)   head x
//  out_y        out  $clog2(GRID_H)   head y
//  health_fail  out  1                sticky RCT failure flag
// BEHAVIOUR
//  Reset: resolution_o=GRID_W, out_valid=0, out_x=out_y=0, health_fail=0, FIFO empty, FSM=WARM, warm_cnt=0, rct_cnt=0.
//  TRNG latency: resolution_o set at edge k -> product uses it at edge k+1 -> random_in valid for capture at edge k+2.
//  FSM (one state change per clk):
//   WARM:     warm_cnt++; at warm_cnt==WARMUP-1 -> HOLD.
//   HOLD:     if en && !health_fail && fifo_count<FIFO_DEPTH -> X_SETTLE, resolution_o<=GRID_W; else stay.
//   X_SETTLE: -> X_CAP (no capture).
//   X_CAP:    if random_in<GRID_W: x_q<=random_in, resolution_o<=GRID_H, -> Y_SETTLE; else stay (reject, retry next clk).
//   Y_SETTLE: -> Y_CAP.
//   Y_CAP:    if random_in<GRID_H: push {x_q,random_in}, resolution_o<=GRID_W, -> HOLD; else stay (reject).
//  Best-case throughput: one coordinate per 5 cycles (HOLD,X_SETTLE,X_CAP,Y_SETTLE,Y_CAP).
//  Push can never find FIFO full: the space check is done in HOLD and only the FSM pushes.
//  FIFO pop on out_valid&&out_ready. Push and pop in the same clk leave the count unchanged. out_x/out_y
//   show the head combinationally from storage; the value is don't-care when out_valid=0.
//  RCT: on every X_CAP/Y_CAP edge, including rejects, compare random_in with the last raw capture.
//   Equal -> rct_cnt++ (saturating); different -> rct_cnt<=1.
//   rct_cnt reaching RCT_CUTOFF -> health_fail<=1 (sticky until rst_n).
//   If health_fail sets on the Y_CAP edge, that push is suppressed. FSM then returns to HOLD and stays.
//   Already buffered FIFO entries still drain.
//  en deasserted outside HOLD: the current coordinate completes; the FSM then stops in HOLD.
//  rst_n low in any state: reset applies on that edge; partially captured x_q is discarded.
//  resolution_o is only ever GRID_W or GRID_H.
// STRUCTURE
//  trng_pkg: typedef enum logic [2:0] {WARM,HOLD,X_SETTLE,X_CAP,Y_SETTLE,Y_CAP} sampler_state_t;
//   default GRID_W/GRID_H constants shared with trng and the sandpile core.
//  Sub-module coord_fifo: synchronous FIFO, parameters DEPTH and WIDTH; push/pop/full/empty/count.
//  Instantiated with WIDTH = x width + y width. FSM, RCT and resolution register stay in this module.
// TESTING
//  1. Reset, en=1, random_in=scripted non-repeating values -> out_valid=0 and resolution_o=20 for the first
//     WARMUP cycles; first push no earlier than WARMUP+5 cycles after reset.
//  2. random_in=7 at X_CAP, 13 at Y_CAP -> out_x=7, out_y=13, out_valid=1 the next clk;
//     resolution_o sequence 20 -> 24 -> 20.
//  3. random_in=22 at X_CAP, then 3 -> first value rejected, FSM stays in X_CAP one extra clk, out_x=3.
//  4. out_ready=0 with 4 coordinates buffered -> FSM parks in HOLD, resolution_o=20; out_ready=1 drains
//     all 4 in push order; simultaneous push/pop keeps count.
//  5. random_in held at 9 across 6 consecutive captures -> health_fail=1 on the 6th capture edge,
//     no further pushes; rst_n pulse clears it.
//  6. rst_n low during Y_SETTLE -> next clk: FSM=WARM, out_valid=0, resolution_o=20, FIFO empty.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG consumer side: sampler FSM states and the default grid bounds
// that the TRNG, this sampler and the sandpile core all agree on.
package trng_pkg;

  localparam int DEFAULT_GRID_W = 20;
  localparam int DEFAULT_GRID_H = 24;
  localparam int TRNG_RAND_W    = 10;
  localparam int TRNG_RES_W     = 9;

  typedef enum logic [2:0] {
    WARM,
    HOLD,
    X_SETTLE,
    X_CAP,
    Y_SETTLE,
    Y_CAP
  } sampler_state_t;

endpackage

// File: rtl/coord_fifo.sv
// Small synchronous FIFO for packed (x,y) coordinates. The head entry is shown combinationally
// from storage; push when full and pop when empty are ignored.
module coord_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/trng_coord_sampler.sv
// Consumer end of the TRNG: steers its resolution input between the grid bounds, captures (x,y)
// grain-drop coordinates into a FIFO, and runs a repetition-count health test on raw captures.
module trng_coord_sampler
  import trng_pkg::*;
#(
  parameter int GRID_W     = DEFAULT_GRID_W,
  parameter int GRID_H     = DEFAULT_GRID_H,
  parameter int WARMUP     = 8,
  parameter int RCT_CUTOFF = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [9:0]                  random_in,
  output logic [8:0]                  resolution_o,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(GRID_W)-1:0]   out_x,
  output logic [$clog2(GRID_H)-1:0]   out_y,
  output logic                        health_fail
);

  localparam int XW  = $clog2(GRID_W);
  localparam int YW  = $clog2(GRID_H);
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [WCW-1:0] WARM_LAST     = WCW'(WARMUP - 1);
  localparam logic [CW-1:0]  FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [8:0]     RES_W         = 9'(GRID_W);
  localparam logic [8:0]     RES_H         = 9'(GRID_H);
  localparam logic [9:0]     LIMIT_W       = 10'(GRID_W);
  localparam logic [9:0]     LIMIT_H       = 10'(GRID_H);
  localparam logic [3:0]     RCT_LIMIT     = 4'(RCT_CUTOFF);

  sampler_state_t   state;
  sampler_state_t   state_n;
  logic [WCW-1:0]   warm_cnt;
  logic [XW-1:0]    x_q;
  logic [3:0]       rct_cnt;
  logic [3:0]       rct_cnt_n;
  logic [9:0]       last_raw;
  logic             capture;
  logic             fail_now;
  logic             fail_any;
  logic             push;
  logic             x_load;
  logic             set_res_w;
  logic             set_res_h;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [XW+YW-1:0] fifo_rdata;

  assign capture   = (state == X_CAP) || (state == Y_CAP);
  assign rct_cnt_n = (random_in != last_raw) ? 4'd1 :
                     (rct_cnt == 4'hF)       ? rct_cnt : rct_cnt + 4'd1;
  assign fail_now  = capture && (rct_cnt_n >= RCT_LIMIT);
  assign fail_any  = health_fail || fail_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WARM;
    end else begin
      state <= state_n;
    end
  end

  // A health failure in Y_CAP drops the pending coordinate and parks the FSM in HOLD.
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    x_load    = 1'b0;
    set_res_w = 1'b0;
    set_res_h = 1'b0;
    case (state)
      WARM: begin
        if (warm_cnt == WARM_LAST) state_n = HOLD;
      end
      HOLD: begin
        if (en && !health_fail && (fifo_count < FIFO_FULL_CNT)) begin
          state_n   = X_SETTLE;
          set_res_w = 1'b1;
        end
      end
      X_SETTLE: state_n = X_CAP;
      X_CAP: begin
        if (random_in < LIMIT_W) begin
          x_load    = 1'b1;
          set_res_h = 1'b1;
          state_n   = Y_SETTLE;
        end
      end
      Y_SETTLE: state_n = Y_CAP;
      Y_CAP: begin
        if (fail_any) begin
          set_res_w = 1'b1;
          state_n   = HOLD;
        end else if (random_in < LIMIT_H) begin
          push      = 1'b1;
          set_res_w = 1'b1;
          state_n   = HOLD;
        end
      end
      default: state_n = WARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolution_o <= RES_W;
      warm_cnt     <= '0;
      x_q          <= '0;
      rct_cnt      <= '0;
      last_raw     <= '0;
      health_fail  <= 1'b0;
    end else begin
      if (state == WARM) warm_cnt <= warm_cnt + 1'b1;
      if (set_res_h) begin
        resolution_o <= RES_H;
      end else if (set_res_w) begin
        resolution_o <= RES_W;
      end
      if (x_load) x_q <= random_in[XW-1:0];
      if (capture) begin
        rct_cnt  <= rct_cnt_n;
        last_raw <= random_in;
      end
      if (fail_now) health_fail <= 1'b1;
    end
  end

  coord_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XW + YW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !fifo_full),
    .pop   (out_ready),
    .wdata ({x_q, random_in[YW-1:0]}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid      = !fifo_empty;
  assign {out_x, out_y} = fifo_rdata;

endmodule
